// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
//   Bundle between the issue/write-back stages and the register file.
//   The master (pipeline) drives the read indices, the write-back port and
//   the issue strobe. The slave (register file) returns the operand data,
//   the per-operand busy flags and the combined stall.
//
//   rs_addr/rt_addr   : read port indices (rs -> ALU input 0, rt -> ALU input 1)
//   rs_data/rt_data   : operand data, combinational, includes write-back bypass
//   wb_en/addr/data   : write-back port
//   iss_en/iss_addr   : issue strobe and destination index of issued instruction
//   busy_rs/busy_rt   : operand still pending on an outstanding producer
//   stall             : busy_rs | busy_rt
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              busy_rs;
  logic              busy_rt;
  logic              stall;

  modport master (
    output rs_addr, rt_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rs_data, rt_data, busy_rs, busy_rt, stall
  );

  modport slave (
    input  rs_addr, rt_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rs_data, rt_data, busy_rs, busy_rt, stall
  );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Register file with a busy scoreboard, feeding the ALU's two operands.
//   Two combinational read ports with write->read bypass, one synchronous
//   write-back port. Each register has a busy bit that is set when an
//   instruction targeting it issues and cleared by its write-back; reads of
//   a busy register raise stall so the issue stage holds the ALU op.
//
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous reset, active-high (clears registers and busy bits)
//     bus  : reg_file_sb_if.slave (read ports, write-back, issue, busy/stall)
//
//   Register 0 is hard-wired to zero and is never busy.
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Registers stay in flops: reads are asynchronous and reset clears them.
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_rs_wb_hit;
  logic                w_rt_wb_hit;
  logic                w_busy_rs;
  logic                w_busy_rt;
  logic                w_stall;
  logic                w_wb_valid;

  // Same-cycle write-back to the index being read (index 0 never bypasses).
  assign w_rs_wb_hit = bus.wb_en && (bus.wb_addr == bus.rs_addr);
  assign w_rt_wb_hit = bus.wb_en && (bus.wb_addr == bus.rt_addr);
  assign w_wb_valid  = bus.wb_en && (bus.wb_addr != '0);

  // A write-back landing this cycle resolves the hazard through the bypass.
  assign w_busy_rs = r_busy[bus.rs_addr] && !w_rs_wb_hit;
  assign w_busy_rt = r_busy[bus.rt_addr] && !w_rt_wb_hit;
  assign w_stall   = w_busy_rs || w_busy_rt;

  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (bus.rs_addr != '0) begin
      bus.rs_data = w_rs_wb_hit ? bus.wb_data : r_regs[bus.rs_addr];
    end
    if (bus.rt_addr != '0) begin
      bus.rt_data = w_rt_wb_hit ? bus.wb_data : r_regs[bus.rt_addr];
    end
  end

  assign bus.busy_rs = w_busy_rs;
  assign bus.busy_rt = w_busy_rt;
  assign bus.stall   = w_stall;

  // Per-index scoreboard decode. An issue presented while stalled is not
  // accepted, so it must not mark its destination.
  assign w_set[0] = 1'b0;
  assign w_clr[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      assign w_set[gi] = bus.iss_en && !w_stall && (bus.iss_addr == ADDR_W'(gi));
      assign w_clr[gi] = bus.wb_en && (bus.wb_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wb_valid) begin
        r_regs[bus.wb_addr] <= bus.wb_data;
      end
      // Set wins over clear: the write-back retires the old producer while
      // the newly issued one is still outstanding.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

endmodule
